// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit BCD counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Upper bound on digit count that all_digits_eq can inspect.
    localparam int unsigned MAX_DIGITS = 16;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

    function automatic logic all_digits_eq(input logic [4*MAX_DIGITS-1:0] vec,
                                           input logic [3:0]              val,
                                           input int unsigned             n);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && vec[4*i +: 4] != val) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_if.sv
// Control/data bundle between a BCD counter and whatever drives it.
interface bcd_counter_ndigit_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  carry;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  count, carry, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output count, carry, load_err
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit register: loads, or steps up/down with 9<->0 rollover.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [3:0] load_nib_i,
    output logic [3:0] digit_o,
    output logic       at_term_o
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_nib_i;
        end else if (step_i) begin
            if (up_i) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o   = digit_q;
    assign at_term_o = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit up/down BCD counter with parallel load, wrap/saturate and terminal-count pulse.
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bcd_counter_ndigit_if.slave  bus
);

    logic [DIGITS-1:0]       at_term;
    logic [DIGITS-1:0]       step_in;
    logic [4*DIGITS-1:0]     count_w;
    logic [4*MAX_DIGITS-1:0] count_ext;
    logic                    load_valid;
    logic                    load_ok;
    logic                    all_term;
    logic                    step_en;
    logic                    carry_q, carry_d;
    logic                    load_err_q, load_err_d;

    always_comb begin
        load_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(bus.load_val[4*k +: 4])) begin
                load_valid = 1'b0;
            end
        end
    end

    assign load_ok = bus.load & load_valid;

    always_comb begin
        count_ext                 = '0;
        count_ext[4*DIGITS-1:0]   = count_w;
        all_term = all_digits_eq(count_ext, bus.up ? BCD_MAX : BCD_MIN, DIGITS);
    end

    // Saturating mode suppresses the step entirely once every digit sits at the terminal value.
    assign step_en = bus.en & ~bus.load & (WRAP | ~all_term);

    always_comb begin
        logic prefix;
        prefix = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            step_in[k] = step_en & prefix;
            prefix     = prefix & at_term[k];
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .step_i     (step_in[k]),
            .up_i       (bus.up),
            .load_i     (load_ok),
            .load_nib_i (bus.load_val[4*k +: 4]),
            .digit_o    (count_w[4*k +: 4]),
            .at_term_o  (at_term[k])
        );
    end

    assign carry_d    = bus.en & ~bus.load & all_term;
    assign load_err_d = bus.load & ~load_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_w;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench: 2-digit wrap, 2-digit saturate and 4-digit wrap counters.
module tb_bcd_counter_ndigit;

    logic clk = 1'b0;
    logic rst2 = 1'b1, rst2s = 1'b1, rst4 = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bcd_counter_ndigit_if #(.DIGITS(2)) if2  ();
    bcd_counter_ndigit_if #(.DIGITS(2)) if2s ();
    bcd_counter_ndigit_if #(.DIGITS(4)) if4  ();

    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b1)) dut2 (
        .clk_i (clk),
        .rst_i (rst2),
        .bus   (if2.slave)
    );

    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b0)) dut2s (
        .clk_i (clk),
        .rst_i (rst2s),
        .bus   (if2s.slave)
    );

    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1'b1)) dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (if4.slave)
    );

    typedef struct {
        bit         rst;
        bit         en;
        bit         up;
        bit         load;
        logic [7:0] val;
        logic [7:0] cnt;
        bit         carry;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic drive2(input bit r, input bit e, input bit u, input bit l, input logic [7:0] v);
        rst2         = r;
        if2.en       = e;
        if2.up       = u;
        if2.load     = l;
        if2.load_val = v;
    endtask

    initial begin
        int exp_val;
        int carries;
        bit exp_c;

        if2.en = 0;  if2.up = 0;  if2.load = 0;  if2.load_val = '0;
        if2s.en = 0; if2s.up = 0; if2s.load = 0; if2s.load_val = '0;
        if4.en = 0;  if4.up = 0;  if4.load = 0;  if4.load_val = '0;

        // Reset held for two edges with En high.
        drive2(1, 1, 1, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            edge_sample();
            check("rst.count", 16'(if2.count), 16'h00);
            check("rst.carry", 16'(if2.carry), 16'h0);
            check("rst.err",   16'(if2.load_err), 16'h0);
        end

        // Full up-count 00..99..00 against a decimal model.
        drive2(0, 1, 1, 0, 8'h00);
        exp_val = 0;
        carries = 0;
        for (int i = 0; i < 100; i++) begin
            exp_c   = (exp_val == 99);
            exp_val = (exp_val + 1) % 100;
            edge_sample();
            check($sformatf("up%0d.count", i), 16'(if2.count), 16'(to_bcd2(exp_val)));
            check($sformatf("up%0d.carry", i), 16'(if2.carry), 16'(exp_c));
            if (if2.carry) carries++;
        end
        check("up.carry_total", 16'(carries), 16'd1);

        // rst, en, up, load, val, expected count, carry, err
        tbl.push_back('{0, 0, 0, 1, 8'h09, 8'h09, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 8'h00, 8'h10, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 8'h00, 8'h09, 0, 0});
        for (int d = 8; d >= 0; d--) begin
            tbl.push_back('{0, 1, 0, 0, 8'h00, to_bcd2(d), 0, 0});
        end
        tbl.push_back('{0, 1, 0, 0, 8'h00, 8'h99, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 8'h42, 8'h42, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 8'h3A, 8'h42, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 8'h42, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 8'h57, 8'h57, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 8'hA5, 8'h57, 0, 1});
        tbl.push_back('{0, 1, 1, 1, 8'h99, 8'h99, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 8'h73, 8'h73, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 8'h11, 8'h00, 0, 0});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{0, 0, 1, 0, 8'h00, 8'h00, 0, 0});
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive2(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].val);
            edge_sample();
            check($sformatf("tbl%0d.count", i), 16'(if2.count), 16'(tbl[i].cnt));
            check($sformatf("tbl%0d.carry", i), 16'(if2.carry), 16'(tbl[i].carry));
            check($sformatf("tbl%0d.err", i),   16'(if2.load_err), 16'(tbl[i].err));
        end
        drive2(0, 0, 0, 0, 8'h00);

        // Saturating counter: holds at 99 going up and at 00 going down.
        edge_sample();
        rst2s = 0;
        if2s.load = 1; if2s.load_val = 8'h98;
        edge_sample();
        check("sat.load", 16'(if2s.count), 16'h98);
        if2s.load = 0; if2s.en = 1; if2s.up = 1;
        edge_sample();
        check("sat.s1.count", 16'(if2s.count), 16'h99);
        check("sat.s1.carry", 16'(if2s.carry), 16'h0);
        edge_sample();
        check("sat.s2.count", 16'(if2s.count), 16'h99);
        check("sat.s2.carry", 16'(if2s.carry), 16'h1);
        edge_sample();
        check("sat.s3.count", 16'(if2s.count), 16'h99);
        check("sat.s3.carry", 16'(if2s.carry), 16'h1);
        if2s.en = 0; if2s.load = 1; if2s.load_val = 8'h00;
        edge_sample();
        check("sat.load0.carry", 16'(if2s.carry), 16'h0);
        if2s.load = 0; if2s.en = 1; if2s.up = 0;
        edge_sample();
        check("sat.dn.count", 16'(if2s.count), 16'h00);
        check("sat.dn.carry", 16'(if2s.carry), 16'h1);
        if2s.en = 0;

        // Four-digit ripple across three digits, then full wrap both ways.
        edge_sample();
        rst4 = 0;
        if4.load = 1; if4.load_val = 16'h0999;
        edge_sample();
        if4.load = 0; if4.en = 1; if4.up = 1;
        edge_sample();
        check("d4.ripple.count", if4.count, 16'h1000);
        check("d4.ripple.carry", 16'(if4.carry), 16'h0);
        if4.en = 0; if4.load = 1; if4.load_val = 16'h9999;
        edge_sample();
        if4.load = 0; if4.en = 1; if4.up = 1;
        edge_sample();
        check("d4.wrap_up.count", if4.count, 16'h0000);
        check("d4.wrap_up.carry", 16'(if4.carry), 16'h1);
        if4.up = 0;
        edge_sample();
        check("d4.wrap_dn.count", if4.count, 16'h9999);
        check("d4.wrap_dn.carry", 16'(if4.carry), 16'h1);
        edge_sample();
        check("d4.dn.count", if4.count, 16'h9998);
        check("d4.dn.carry", 16'(if4.carry), 16'h0);
        if4.en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
